// File: rtl/fft_pkg.sv
// Shared constants for the 64-point mixed-radix FFT pipeline.
// Holds the fixed-point format defaults and the W8 twiddle address encoding.
package fft_pkg;

  localparam int unsigned DEF_INTEGER_SIZE = 5;
  localparam int unsigned DEF_FRACT_SIZE   = 10;
  localparam int unsigned DEF_DATA_WIDTH   = DEF_INTEGER_SIZE + DEF_FRACT_SIZE;

  // Fixed-point 1.0 in the default format
  localparam int FIXED_ONE = 1024;

  typedef enum logic [5:0] {
    TwW0 = 6'd0,
    TwW1 = 6'd1,
    TwW2 = 6'd2,
    TwW3 = 6'd3
  } tw_addr_e;

endpackage

// File: rtl/sdf_delay_line.sv
// Circular feedback buffer: write-then-advance pointer, read port shows the oldest entry.
// Contents are not reset; only the pointer is.
module sdf_delay_line #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    ptr_q, ptr_d;

  always_comb begin
    ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (en) begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
  end

  // Full buffer: the slot about to be overwritten holds the oldest entry
  assign dout = mem_q[ptr_q];

endmodule

// File: rtl/sdf_r2_bf_stage.sv
// Radix-2 DIF single-path delay-feedback butterfly stage feeding the W8 constant multiplier.
// One complex sample per valid cycle; registered outputs with latency 1.
module sdf_r2_bf_stage
  import fft_pkg::*;
#(
  parameter int unsigned INTEGER_SIZE = DEF_INTEGER_SIZE,
  parameter int unsigned FRACT_SIZE   = DEF_FRACT_SIZE,
  parameter int unsigned DELAY        = 4,
  parameter int unsigned SCALE        = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in_r,
  input  logic [INTEGER_SIZE+FRACT_SIZE-1:0]  in_i,
  output logic                                out_valid,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0]  out_r,
  output logic [INTEGER_SIZE+FRACT_SIZE-1:0]  out_i,
  output logic [5:0]                          tw_addr
);

  localparam int unsigned DW = INTEGER_SIZE + FRACT_SIZE;
  localparam int unsigned CW = $clog2(2 * DELAY);
  localparam int unsigned LD = $clog2(DELAY);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic            primed_q, primed_d;
  logic            phase_b;
  logic [DW-1:0]   h_r, h_i;
  logic [DW:0]     sum_r, sum_i, dif_r, dif_i;
  logic [DW-1:0]   sum_r_s, sum_i_s, dif_r_s, dif_i_s;
  logic [DW-1:0]   res_r, res_i, push_r, push_i;
  logic [5:0]      tw_d;

  sdf_delay_line #(
    .WIDTH (2 * DW),
    .DEPTH (DELAY)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  ({push_r, push_i}),
    .dout ({h_r, h_i})
  );

  // 2*DELAY is a power of two, so the counter MSB marks the second half-frame
  assign phase_b = cnt_q[CW-1];

  always_comb begin
    sum_r = {h_r[DW-1], h_r} + {in_r[DW-1], in_r};
    sum_i = {h_i[DW-1], h_i} + {in_i[DW-1], in_i};
    dif_r = {h_r[DW-1], h_r} - {in_r[DW-1], in_r};
    dif_i = {h_i[DW-1], h_i} - {in_i[DW-1], in_i};
    if (SCALE != 0) begin
      sum_r_s = sum_r[DW:1];
      sum_i_s = sum_i[DW:1];
      dif_r_s = dif_r[DW:1];
      dif_i_s = dif_i[DW:1];
    end else begin
      sum_r_s = sum_r[DW-1:0];
      sum_i_s = sum_i[DW-1:0];
      dif_r_s = dif_r[DW-1:0];
      dif_i_s = dif_i[DW-1:0];
    end
  end

  always_comb begin
    if (phase_b) begin
      res_r  = sum_r_s;
      res_i  = sum_i_s;
      push_r = dif_r_s;
      push_i = dif_i_s;
      tw_d   = TwW0;
    end else begin
      res_r  = h_r;
      res_i  = h_i;
      push_r = in_r;
      push_i = in_i;
      tw_d   = 6'(cnt_q >> (LD - 2));
    end
    cnt_d    = cnt_q + CW'(1);
    primed_d = primed_q | (cnt_q == {CW{1'b1}});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      primed_q  <= 1'b0;
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
      tw_addr   <= '0;
    end else begin
      // Frame-0 Phase A reads an unwritten buffer; primed masks it
      out_valid <= in_valid & (primed_q | phase_b);
      if (in_valid) begin
        cnt_q    <= cnt_d;
        primed_q <= primed_d;
        out_r    <= res_r;
        out_i    <= res_i;
        tw_addr  <= tw_d;
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_bf_stage.sv
// Bench for the SDF radix-2 butterfly: impulse table, scoreboard model, stall/overflow/reset.
module tb_sdf_r2_bf_stage;

  localparam int DW = 15;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_r, in_i;
  logic          ov0, ov1;
  logic [DW-1:0] or0, oi0, or1, oi1;
  logic [5:0]    tw0, tw1;

  sdf_r2_bf_stage #(.DELAY(4), .SCALE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(ov0), .out_r(or0), .out_i(oi0), .tw_addr(tw0)
  );

  sdf_r2_bf_stage #(.DELAY(4), .SCALE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_r(in_r), .in_i(in_i),
    .out_valid(ov1), .out_r(or1), .out_i(oi1), .tw_addr(tw1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int r0; int i0; int r1; int i1; int tw;
  } exp_t;

  typedef struct {
    bit v; int r; int i; bit ev; int er; int ei; int etw;
  } vec_t;

  exp_t sbq[$];
  vec_t imp_tab[12];
  int total = 0;
  int bad = 0;

  // Frame-level reference model
  int m_cnt;
  bit m_primed;
  int xr[8], xi[8], dr[4], di[4];

  function automatic int wrap15(int v);
    logic [14:0] t;
    t = v[14:0];
    return int'($signed(t));
  endfunction

  function automatic int half(int v);
    return v >>> 1;
  endfunction

  function automatic int sx(logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_primed = 0;
    for (int k = 0; k < 4; k++) begin dr[k] = 0; di[k] = 0; end
    sbq.delete();
  endtask

  task automatic model_accept(input bit v, input int r, input int i, output bit ev);
    exp_t e;
    int j, k, sr, si;
    ev = 0;
    if (v) begin
      j = m_cnt;
      if (j < 4) begin
        xr[j] = r;
        xi[j] = i;
        if (m_primed) begin
          e = '{wrap15(dr[j]), wrap15(di[j]), half(dr[j]), half(di[j]), j};
          sbq.push_back(e);
          ev = 1;
        end
      end else begin
        k = j - 4;
        sr = xr[k] + r;
        si = xi[k] + i;
        e = '{wrap15(sr), wrap15(si), half(sr), half(si), 0};
        sbq.push_back(e);
        dr[k] = xr[k] - r;
        di[k] = xi[k] - i;
        ev = 1;
      end
      if (j == 7) m_primed = 1;
      m_cnt = (j + 1) % 8;
    end
  endtask

  // Called at a negedge; returns at the next negedge after outputs are checked
  task automatic step(input bit v, input int r, input int i);
    bit ev;
    exp_t e;
    in_valid = v;
    in_r = r[DW-1:0];
    in_i = i[DW-1:0];
    @(posedge clk);
    model_accept(v, r, i, ev);
    @(negedge clk);
    chk("out_valid0", int'(ov0), int'(ev));
    chk("out_valid1", int'(ov1), int'(ev));
    if (ev) begin
      if (sbq.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sbq.pop_front();
        chk("out_r0", sx(or0), e.r0);
        chk("out_i0", sx(oi0), e.i0);
        chk("out_r1", sx(or1), e.r1);
        chk("out_i1", sx(oi1), e.i1);
        chk("tw_addr0", int'(tw0), e.tw);
        chk("tw_addr1", int'(tw1), e.tw);
      end
    end
  endtask

  task automatic do_reset();
    in_valid = 0;
    in_r = '0;
    in_i = '0;
    #2 rst = 0;
    @(negedge clk);
    model_reset();
    rst = 1;
  endtask

  task automatic run_impulse_table();
    for (int n = 0; n < 12; n++) begin
      step(imp_tab[n].v, imp_tab[n].r, imp_tab[n].i);
      chk("tab_valid", int'(ov0), int'(imp_tab[n].ev));
      if (imp_tab[n].ev) begin
        chk("tab_r", sx(or0), imp_tab[n].er);
        chk("tab_i", sx(oi0), imp_tab[n].ei);
        chk("tab_tw", int'(tw0), imp_tab[n].etw);
      end
    end
  endtask

  initial begin
    // Impulse frame then 4 zeros: sums 1024,0,0,0 then diffs 1024,0,0,0 on tw 0..3
    imp_tab[0]  = '{1, 1024, 0, 0, 0, 0, 0};
    imp_tab[1]  = '{1, 0, 0, 0, 0, 0, 0};
    imp_tab[2]  = '{1, 0, 0, 0, 0, 0, 0};
    imp_tab[3]  = '{1, 0, 0, 0, 0, 0, 0};
    imp_tab[4]  = '{1, 0, 0, 1, 1024, 0, 0};
    imp_tab[5]  = '{1, 0, 0, 1, 0, 0, 0};
    imp_tab[6]  = '{1, 0, 0, 1, 0, 0, 0};
    imp_tab[7]  = '{1, 0, 0, 1, 0, 0, 0};
    imp_tab[8]  = '{1, 0, 0, 1, 1024, 0, 0};
    imp_tab[9]  = '{1, 0, 0, 1, 0, 0, 1};
    imp_tab[10] = '{1, 0, 0, 1, 0, 0, 2};
    imp_tab[11] = '{1, 0, 0, 1, 0, 0, 3};

    rst = 0;
    in_valid = 0;
    in_r = '0;
    in_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(ov0), 0);
    chk("rst_r", sx(or0), 0);
    chk("rst_i", sx(oi0), 0);
    chk("rst_tw", int'(tw0), 0);
    rst = 1;
    @(negedge clk);

    run_impulse_table();

    // Constant input
    do_reset();
    for (int n = 0; n < 8; n++) step(1, 512, 256);
    for (int n = 0; n < 4; n++) step(1, 0, 0);

    // Stall on alternate cycles; a bubble must give out_valid=0 next cycle
    do_reset();
    for (int n = 0; n < 12; n++) begin
      step(0, 0, 0);
      step(1, imp_tab[n].r, imp_tab[n].i);
    end

    // Overflow at the positive full-scale edge
    do_reset();
    step(1, 16383, 0);
    for (int n = 0; n < 3; n++) step(1, 0, 0);
    step(1, 1, 0);
    chk("ovf_sum0", sx(or0), -16384);
    chk("ovf_sum1", sx(or1), 8192);
    for (int n = 0; n < 3; n++) step(1, 0, 0);
    step(1, 0, 0);
    chk("ovf_dif0", sx(or0), 16382);
    chk("ovf_dif1", sx(or1), 8191);
    for (int n = 0; n < 3; n++) step(1, 0, 0);

    // Back-to-back random frames with occasional stalls
    do_reset();
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(3) == 0) step(0, 0, 0);
      step(1, int'($urandom_range(8000)) - 4000, int'($urandom_range(8000)) - 4000);
    end
    for (int n = 0; n < 4; n++) step(1, 0, 0);

    // Reset at cnt=5: outputs clear without a clock edge, then a fresh frame
    do_reset();
    step(1, 1024, 0);
    for (int n = 0; n < 4; n++) step(1, 0, 0);
    chk("pre_rst_r", sx(or0), 1024);
    #2 rst = 0;
    #1;
    chk("async_valid", int'(ov0), 0);
    chk("async_r", sx(or0), 0);
    chk("async_i", sx(oi0), 0);
    chk("async_tw", int'(tw0), 0);
    @(negedge clk);
    model_reset();
    rst = 1;
    run_impulse_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdf_r2_bf_stage.md
Name: sdf_r2_bf_stage

Overview:
- Single-path delay-feedback (SDF) radix-2 DIF butterfly stage for the 64-point mixed-radix pipeline.
- Sits directly upstream of the constant (W8) twiddle multiplier. Drives that multiplier's complex data inputs and its 6-bit address input from an internal sample counter.
- Accepts one complex sample per valid cycle. Emits butterfly sums and differences in natural SDF order.

Parameters:
- INTEGER_SIZE, 5, integer bits of the signed fixed-point sample.
- FRACT_SIZE, 10, fractional bits; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE (15).
- DELAY, 4, feedback depth in samples; butterfly span; power of two, >= 4.
- SCALE, 0, 1 = divide sum and difference by 2 (arithmetic shift right).

Ports:
- clk, input, 1, single clock; rising edge.
- rst, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_r/in_i hold a sample this cycle; low = stall.
- in_r, input, DATA_WIDTH, signed real part.
- in_i, input, DATA_WIDTH, signed imaginary part.
- out_valid, output, 1, out_r/out_i/tw_addr are meaningful.
- out_r, output, DATA_WIDTH, signed real result.
- out_i, output, DATA_WIDTH, signed imaginary result.
- tw_addr, output, 6, twiddle address for the downstream constant multiplier (0..3 used).

Behaviour:
- Reset (rst low, asynchronous): cnt=0, primed=0, FIFO pointer=0. out_valid=0, out_r=0, out_i=0, tw_addr=0. FIFO contents are not reset (never observable).
- Counter cnt: log2(2*DELAY) bits. Increments only on in_valid. Wraps 2*DELAY-1 -> 0. in_valid low freezes all state (cnt, FIFO, primed); outputs hold their values and out_valid drops to 0 the next cycle.
- Feedback FIFO holds DELAY complex entries. On every valid cycle it pops head h and pushes exactly one entry, so occupancy is always DELAY.
- Phase A (cnt < DELAY):
  - push x.
  - result = h (the stored difference from the previous frame).
  - tw_addr = cnt >> (log2(DELAY)-2), giving 0..3.
- Phase B (cnt >= DELAY):
  - result = h + x.
  - push h - x.
  - tw_addr = 0.
- Arithmetic:
  - Sum and difference are computed in DATA_WIDTH+1 bits.
  - SCALE=0: keep the low DATA_WIDTH bits (two's-complement wrap).
  - SCALE=1: keep bits [DATA_WIDTH:1] (floor divide).
  - Phase A pass-through is never rescaled.
- Output register, latency 1:
  - result, tw_addr and out_valid are registered on the clock edge after the accepting cycle.
  - out_valid = registered (in_valid & (primed | cnt >= DELAY)).
- primed sets on the first valid cycle with cnt = 2*DELAY-1. It stays set until reset, which masks the garbage Phase A output of frame 0.
- Ordering:
  - The sum for pair (x[j], x[j+DELAY]) appears 1 cycle after x[j+DELAY] is accepted.
  - Its difference appears 1 cycle after the j-th valid sample of the next frame is accepted.
  - To drain the last frame, drive DELAY further valid samples (zeros).
- Reset mid-frame: state aborts immediately. The next valid sample is treated as frame 0, index 0, and primed is cleared.

Decomposition:
- Shared package fft_pkg holds:
  - INTEGER_SIZE, FRACT_SIZE and DATA_WIDTH defaults.
  - The W8 address encoding: 0 = W0, 1 = W1, 2 = W2, 3 = W3.
  - The fixed-point constant 1.0 = 1024.
- One sub-module: sdf_delay_line, a parameterised circular buffer (WIDTH=2*DATA_WIDTH, DEPTH=DELAY) with a single enable.
  - Write-then-advance pointer.
  - The read port returns the oldest entry.
  - The pointer resets asynchronously.

Test Plan:
- Impulse (DELAY=4, SCALE=0): frame 1024,0,0,0,0,0,0,0, then 4 zeros.
  - Valid outputs: 1024,0,0,0 (sums, tw_addr 0).
  - Then 1024,0,0,0 (diffs, tw_addr 0,1,2,3).
  - Imaginary parts all 0.
- Constant 512+j256 for 8 samples, then 4 zeros.
  - Sums: 1024+j512 ×4.
  - Diffs: 0 ×4.
  - out_valid low during the first 4 accepts.
- Stall: repeat the impulse test with in_valid low on alternate cycles.
  - The valid output sequence is identical.
  - out_valid is never high in a cycle following an in_valid=0 cycle.
- Overflow: x[0]=16383, x[4]=1.
  - SCALE=0: sum -16384, diff 16382.
  - SCALE=1: sum 8192, diff 8191.
- Back-to-back frames: frame B's sums are interleaved correctly after frame A's diffs, and tw_addr cycles 0,1,2,3,0,0,0,0.
- Reset: assert rst at cnt=5 mid-frame.
  - Outputs go to 0 asynchronously.
  - After release, a fresh impulse frame reproduces the impulse test exactly, with out_valid low for the first 4 accepts.
